// File: rtl/lu_ctrl_pkg.sv
// Shared control definitions for the long-latency unit and its ID-stage scoreboard.
package lu_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int unsigned GPR_CNT = 32;

  // Long-unit op class, shared by the ID decoder and the long unit.
  typedef enum logic [1:0] {
    LU_OP_NONE = 2'd0,
    LU_OP_MUL  = 2'd1,
    LU_OP_DIV  = 2'd2,
    LU_OP_DIVU = 2'd3
  } lu_op_e;

endpackage

// File: rtl/lu_out_counter.sv
// Saturating up/down count of long ops in flight, with flush, full flag and underflow detect.
module lu_out_counter
  import lu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             empty;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_W'(MAX_OUT));
  // A completion with nothing in flight is bogus; flush discards it.
  assign underflow = dec & empty & ~flush;
  assign cnt       = cnt_q;

  // Next count: a bogus completion is dropped so the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else if (inc && !(dec && !empty)) begin
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && dec && !empty) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lu_scoreboard.sv
// Issue-side GPR scoreboard for the long-latency unit: busy bits, ID stall and in-flight limit.
module lu_scoreboard
  import lu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned CNT_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [4:0]       id_rd,
  input  logic             id_regwrite,
  input  logic             id_long,
  input  logic             pipe_en,
  input  logic             lu_done,
  input  logic [4:0]       lu_rd,
  input  logic             flush,
  output logic             stall_id,
  output logic             issue_fire,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] out_cnt,
  output logic             lu_full,
  output logic             err
);

  logic [GPR_CNT-1:0] busy_q;
  logic [GPR_CNT-1:0] busy_d;
  logic               err_q;
  logic               raw;
  logic               waw;
  logic               cap;
  logic               set_busy;
  logic               clr_busy;
  logic               ghost_done;
  logic               underflow;
  logic               cnt_inc;

  // Hazards look only at registered state: a completion is not bypassed into the same cycle.
  always_comb begin
    raw = (id_rs_used && id_rs != REG_ZERO && busy_q[id_rs]) ||
          (id_rt_used && id_rt != REG_ZERO && busy_q[id_rt]);
    waw = id_regwrite && id_rd != REG_ZERO && busy_q[id_rd];
    cap = id_long && lu_full;
  end

  assign stall_id   = id_valid & (raw | waw | cap);
  assign issue_fire = id_valid & pipe_en & ~stall_id & ~flush;

  assign cnt_inc    = issue_fire & id_long;
  assign set_busy   = cnt_inc & id_regwrite & (id_rd != REG_ZERO);
  assign clr_busy   = lu_done & (lu_rd != REG_ZERO);
  assign ghost_done = clr_busy & ~busy_q[lu_rd] & ~flush;

  lu_out_counter #(
    .MAX_OUT (MAX_OUT),
    .CNT_W   (CNT_W)
  ) u_out_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .inc       (cnt_inc),
    .dec       (lu_done),
    .cnt       (out_cnt),
    .full      (lu_full),
    .underflow (underflow)
  );

  // Next busy vector; set and clear never target the same register since waw blocks that issue.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (set_busy) busy_d[id_rd] = 1'b1;
      if (clr_busy) busy_d[lu_rd] = 1'b0;
    end
    busy_d[REG_ZERO] = 1'b0;
  end

  // Busy bits and sticky protocol error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (underflow || ghost_done) err_q <= 1'b1;
    end
  end

  assign busy_mask = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lu_scoreboard.sv
// Directed bench for lu_scoreboard with a cycle-level reference model and literal spot checks.
module tb_lu_scoreboard;

  localparam int MAX = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_rs_used, id_rt_used, id_regwrite, id_long;
  logic       pipe_en, lu_done, flush;
  logic [4:0] id_rs, id_rt, id_rd, lu_rd;
  logic       stall_id, issue_fire, lu_full, err;
  logic [31:0] busy_mask;
  logic [1:0]  out_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: which registers await a long result, how many ops are out, error seen.
  bit m_busy [32];
  int m_cnt;
  bit m_err;

  lu_scoreboard #(.MAX_OUT(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_long(id_long), .pipe_en(pipe_en),
    .lu_done(lu_done), .lu_rd(lu_rd), .flush(flush), .stall_id(stall_id),
    .issue_fire(issue_fire), .busy_mask(busy_mask), .out_cnt(out_cnt),
    .lu_full(lu_full), .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit m_stall();
    bit hz;
    hz = (id_rs_used && id_rs != 0 && m_busy[id_rs]) ||
         (id_rt_used && id_rt != 0 && m_busy[id_rt]) ||
         (id_regwrite && id_rd != 0 && m_busy[id_rd]) ||
         (id_long && m_cnt == MAX);
    return id_valid && hz;
  endfunction

  function automatic bit m_issue();
    return id_valid && pipe_en && !m_stall() && !flush;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // Model state update from the architectural rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
      m_err = 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      m_cnt = 0;
    end else begin
      bit fire;
      int nc;
      fire = m_issue();
      nc = m_cnt;
      if (lu_done) begin
        if (m_cnt == 0) m_err = 1'b1;
        else            nc = nc - 1;
        if (lu_rd != 0 && !m_busy[lu_rd]) m_err = 1'b1;
        if (lu_rd != 0) m_busy[lu_rd] = 1'b0;
      end
      if (fire && id_long) begin
        nc = nc + 1;
        if (id_regwrite && id_rd != 0) m_busy[id_rd] = 1'b1;
      end
      m_cnt = nc;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] got [6];
    logic [31:0] exp [6];
    string nm [6];
    got[0] = 32'(stall_id);   exp[0] = 32'(m_stall());     nm[0] = "stall_id";
    got[1] = 32'(issue_fire); exp[1] = 32'(m_issue());     nm[1] = "issue_fire";
    got[2] = busy_mask;       exp[2] = m_mask();           nm[2] = "busy_mask";
    got[3] = 32'(out_cnt);    exp[3] = 32'(m_cnt);         nm[3] = "out_cnt";
    got[4] = 32'(lu_full);    exp[4] = 32'(m_cnt == MAX);  nm[4] = "lu_full";
    got[5] = 32'(err);        exp[5] = 32'(m_err);         nm[5] = "err";
    for (int i = 0; i < 6; i++) begin
      total++;
      if (got[i] !== exp[i]) begin
        bad++;
        $display("FAIL model %s @%0t: got=%h want=%h", nm[i], $time, got[i], exp[i]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @%0t: got=%h want=%h", name, $time, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
    id_rd = 0; id_regwrite = 0; id_long = 0; pipe_en = 1;
    lu_done = 0; lu_rd = 0; flush = 0;
  endtask

  task automatic set_long(input logic [4:0] rd, input logic wr);
    idle();
    id_valid = 1; id_long = 1; id_regwrite = wr; id_rd = rd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("reset_busy", busy_mask, 32'h0);
    chk("reset_cnt", 32'(out_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    #10 rst_n = 1;
    tick();

    // 1: long rd=8, then add reading $8.
    set_long(5'd8, 1); #2;
    chk("t1_issue_long", 32'(issue_fire), 32'd1);
    tick();
    idle(); id_valid = 1; id_rs = 8; id_rs_used = 1; id_rd = 3; id_regwrite = 1; #2;
    chk("t1_raw_stall", 32'(stall_id), 32'd1);
    chk("t1_busy8", busy_mask, 32'h0000_0100);
    tick(); #2;
    chk("t1_still_stall", 32'(stall_id), 32'd1);
    lu_done = 1; lu_rd = 8; #2;
    chk("t1_no_bypass", 32'(stall_id), 32'd1);
    tick();
    lu_done = 0; #2;
    chk("t1_unstall", 32'(stall_id), 32'd0);
    chk("t1_issue_add", 32'(issue_fire), 32'd1);
    chk("t1_busy_clr", busy_mask, 32'h0);
    tick();

    // pipe_en low with no hazard.
    idle(); id_valid = 1; id_rd = 4; id_regwrite = 1; pipe_en = 0; #2;
    chk("pe_stall", 32'(stall_id), 32'd0);
    chk("pe_issue", 32'(issue_fire), 32'd0);
    tick();

    // 2: WAW on rd=9.
    set_long(5'd9, 1); tick();
    idle(); id_valid = 1; id_rs = 1; id_rs_used = 1; id_rd = 9; id_regwrite = 1; #2;
    chk("t2_waw", 32'(stall_id), 32'd1);
    lu_done = 1; lu_rd = 9; #2;
    chk("t2_waw_done", 32'(stall_id), 32'd1);
    tick();
    lu_done = 0; #2;
    chk("t2_free", 32'(stall_id), 32'd0);
    tick();

    // 3: in-flight cap.
    set_long(5'd10, 1); tick();
    set_long(5'd11, 1); tick();
    set_long(5'd12, 1); #2;
    chk("t3_cnt2", 32'(out_cnt), 32'd2);
    chk("t3_full", 32'(lu_full), 32'd1);
    chk("t3_cap", 32'(stall_id), 32'd1);
    lu_done = 1; lu_rd = 10; #2;
    chk("t3_cap_done", 32'(stall_id), 32'd1);
    tick();
    lu_done = 0; #2;
    chk("t3_cnt1", 32'(out_cnt), 32'd1);
    chk("t3_issue", 32'(issue_fire), 32'd1);
    tick(); #2;
    chk("t3_cnt_back2", 32'(out_cnt), 32'd2);
    chk("t3_mask", busy_mask, 32'h0000_1800);

    // 4: flush with simultaneous done.
    set_long(5'd13, 1); flush = 1; lu_done = 1; lu_rd = 11; #2;
    chk("t4_no_issue", 32'(issue_fire), 32'd0);
    tick();
    idle(); #2;
    chk("t4_mask", busy_mask, 32'h0);
    chk("t4_cnt", 32'(out_cnt), 32'd0);
    chk("t4_err", 32'(err), 32'd0);
    tick();

    // 5: underflow error, then async reset mid-cycle.
    lu_done = 1; lu_rd = 12; tick();
    lu_done = 0; #2;
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_cnt0", 32'(out_cnt), 32'd0);
    tick(); #2;
    chk("t5_err_sticky", 32'(err), 32'd1);
    set_long(5'd14, 1); tick();
    idle(); #2;
    rst_n = 0; #1;
    chk("t5_async_err", 32'(err), 32'd0);
    chk("t5_async_mask", busy_mask, 32'h0);
    chk("t5_async_cnt", 32'(out_cnt), 32'd0);
    tick(); rst_n = 1; tick();

    // Completion for a register that is not busy.
    set_long(5'd15, 0); tick();
    idle(); lu_done = 1; lu_rd = 15; #2;
    chk("t5b_mask0", busy_mask, 32'h0);
    tick();
    lu_done = 0; #2;
    chk("t5b_err", 32'(err), 32'd1);
    chk("t5b_cnt", 32'(out_cnt), 32'd0);
    tick();

    // 6: register 0 is never busy.
    set_long(5'd5, 1); tick();
    set_long(5'd0, 1); id_rs = 0; id_rt = 0; id_rs_used = 1; id_rt_used = 1; #2;
    chk("t6_stall", 32'(stall_id), 32'd0);
    chk("t6_issue", 32'(issue_fire), 32'd1);
    tick();
    idle(); lu_done = 1; lu_rd = 0; #2;
    chk("t6_cnt2", 32'(out_cnt), 32'd2);
    chk("t6_mask", busy_mask, 32'h0000_0020);
    tick();
    lu_rd = 5; #2;
    chk("t6_cnt1", 32'(out_cnt), 32'd1);
    tick();
    idle(); #2;
    chk("t6_cnt0", 32'(out_cnt), 32'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
